// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and flush. Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, empty_reg, af_reg, ae_reg;
  logic          overflow_reg, underflow_reg;
  logic          rd_acc, wr_acc;
  logic          clear;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_acc = rd_en & ~empty_reg;
  assign wr_acc = wr_en & (~full_reg | rd_acc);
  assign clear  = ~rst_n | flush;

  always_comb begin
    wr_ptr_next = wr_acc ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = rd_acc ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next  = count_reg + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!clear && wr_acc) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      af_reg        <= 1'b0;
      ae_reg        <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == CW'(DEPTH));
      empty_reg     <= (count_next == '0);
      af_reg        <= (int'(count_next) >= AF_THRESH);
      ae_reg        <= (int'(count_next) <= AE_THRESH);
      overflow_reg  <= wr_en & ~wr_acc;
      underflow_reg <= rd_en & empty_reg;
    end
  end

  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // Head word is shown as soon as the registered empty flag drops.
  assign data_out = empty_reg ? '0 : mem[rd_ptr_reg];
  assign rd_valid = ~empty_reg;
`else
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  rd_valid_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else if (rd_acc) begin
      data_out_reg <= mem[rd_ptr_reg];
      rd_valid_reg <= 1'b1;
    end else begin
      rd_valid_reg <= 1'b0;
    end
  end

  assign data_out = data_out_reg;
  assign rd_valid = rd_valid_reg;
`endif

endmodule
